// File: rtl/sr195_load_sequencer.sv
// -----------------------------------------------------------------------------
// sr195_load_sequencer
//
// Upstream controller for an SN74LS195A-style shift register stage. Takes one
// parallel word per valid/ready handshake, parallel-loads it into the register
// (PE low for one cycle), then drives J/K for LENGTH shift cycles. After that it
// pulses frame_done and spends GAP_CYCLES idle cycles before it accepts the
// next word. The clock (CP) and reset (MR) are shared with the register stage.
//
// Parameters
//   LENGTH      word width and number of shift cycles
//   GAP_CYCLES  idle cycles after each frame before in_ready reasserts (>= 0)
//
// Ports
//   CP          in   clock, rising edge
//   MR          in   asynchronous reset, active-low
//   in_valid    in   upstream word valid
//   in_data     in   [LENGTH-1:0] word to load
//   in_ready    out  sequencer can accept a word (IDLE)
//   fill_bit    in   serial bit shifted into stage 0, sampled at the handshake
//   P           out  [LENGTH-1:0] parallel data to the shift register
//   PE          out  parallel enable, active-low (0 = load)
//   J           out  J input of shift register stage 0
//   K           out  K-bar input of shift register stage 0
//   busy        out  1 in LOAD, SHIFT and GAP
//   frame_done  out  one-cycle pulse on the last SHIFT cycle
//
// Optional feature (macro SR195_ROTATE_EN):
//   q3_fb       in   Q[LENGTH-1] fed back from the shift register
//   rotate      in   sampled at the handshake; 1 = recirculate the word
// -----------------------------------------------------------------------------
module sr195_load_sequencer #(
  parameter int LENGTH     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] in_data,
  output logic              in_ready,
  input  logic              fill_bit,
`ifdef SR195_ROTATE_EN
  input  logic              q3_fb,
  input  logic              rotate,
`endif
  output logic [LENGTH-1:0] P,
  output logic              PE,
  output logic              J,
  output logic              K,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // One counter serves both SHIFT and GAP, so it is sized for the larger span.
  localparam int CNT_MAX = (LENGTH > GAP_CYCLES) ? LENGTH : GAP_CYCLES;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(LENGTH - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [LENGTH-1:0] p_q;
  logic              pe_q;
  logic              j_q;
  logic              k_q;
  logic              fill_q;
`ifdef SR195_ROTATE_EN
  logic              rot_q;
`endif

  // Outputs are registered together with the state transition, so the value
  // that belongs to a state is on the pins for the whole cycle spent in it and
  // the shift register samples it at the edge that ends that cycle.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state  <= S_IDLE;
      count  <= '0;
      p_q    <= '0;
      pe_q   <= 1'b1;
      j_q    <= 1'b0;
      k_q    <= 1'b1;
      fill_q <= 1'b0;
`ifdef SR195_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // P doubles as the word holding register; it is not touched again
            // until the next handshake, so late in_data changes cannot leak in.
            p_q    <= in_data;
            pe_q   <= 1'b0;
            fill_q <= fill_bit;
`ifdef SR195_ROTATE_EN
            rot_q  <= rotate;
`endif
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          pe_q  <= 1'b1;
          j_q   <= fill_q;
          k_q   <= fill_q;
          count <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (count == SHIFT_LAST) begin
            // Return J/K to hold before leaving the frame.
            j_q   <= 1'b0;
            k_q   <= 1'b1;
            count <= '0;
            state <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_GAP: begin
          if (count == GAP_LAST) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
          pe_q  <= 1'b1;
          j_q   <= 1'b0;
          k_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_SHIFT) && (count == SHIFT_LAST);
  assign P          = p_q;
  assign PE         = pe_q;

`ifdef SR195_ROTATE_EN
  // Recirculation must feed back the register's current Q3; a registered copy
  // would lag one shift behind, so the feedback path bypasses j_q/k_q.
  assign J = (rot_q && state == S_SHIFT) ? q3_fb : j_q;
  assign K = (rot_q && state == S_SHIFT) ? q3_fb : k_q;
`else
  assign J = j_q;
  assign K = k_q;
`endif

endmodule

// File: tb/tb_sr195_load_sequencer.sv
module tb_sr195_load_sequencer;

  localparam int L = 4;

  typedef struct {
    logic [3:0] w;
    logic       f;
    logic       r;
    logic       noise;
    logic [3:0] exp_stream;
    logic [3:0] exp_q;
  } vec_t;

  typedef struct {
    logic [3:0] stream;
    logic [3:0] q;
  } exp_t;

  logic       CP = 1'b0;
  logic       MR = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       fill_bit = 1'b0;
  logic       rotate = 1'b0;
  logic       in_ready, PE, J, K, busy, frame_done;
  logic [3:0] P;

  logic       g_valid = 1'b0;
  logic [3:0] g_data = '0;
  logic       g_fill = 1'b0;
  logic       g_ready, g_PE, g_J, g_K, g_busy, g_fd;
  logic [3:0] g_P;

  logic [3:0] q;
  logic [3:0] stream;
  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;

  always #5 CP = ~CP;

  sr195_load_sequencer #(.LENGTH(L), .GAP_CYCLES(0)) dut (
    .CP(CP), .MR(MR), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fill_bit(fill_bit),
`ifdef SR195_ROTATE_EN
    .q3_fb(q[3]), .rotate(rotate),
`endif
    .P(P), .PE(PE), .J(J), .K(K), .busy(busy), .frame_done(frame_done)
  );

  sr195_load_sequencer #(.LENGTH(L), .GAP_CYCLES(2)) dut_gap (
    .CP(CP), .MR(MR), .in_valid(g_valid), .in_data(g_data),
    .in_ready(g_ready), .fill_bit(g_fill),
`ifdef SR195_ROTATE_EN
    .q3_fb(1'b0), .rotate(1'b0),
`endif
    .P(g_P), .PE(g_PE), .J(g_J), .K(g_K), .busy(g_busy), .frame_done(g_fd)
  );

  // Behavioural LS195 driven by the main sequencer: Q0 <- J/K-bar, Q[i] <- Q[i-1].
  always @(posedge CP or negedge MR) begin
    if (!MR) q <= '0;
    else if (!PE) q <= P;
    else begin
      case ({J, K})
        2'b00: q <= {q[2:0], 1'b0};
        2'b11: q <= {q[2:0], 1'b1};
        2'b01: q <= {q[2:0], q[0]};
        default: q <= {q[2:0], ~q[0]};
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard consumer: collect the Q3 serial stream during SHIFT and compare
  // it and the final register contents when frame_done appears.
  always @(negedge CP) begin
    exp_t e;
    if (MR === 1'b1 && busy && PE) stream = {stream[2:0], q[3]};
    if (MR === 1'b1 && frame_done) begin
      chk("fd_vs_ready", in_ready, 0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_frame_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_stream", stream, e.stream);
        @(posedge CP);
        #1;
        chk("sb_final_q", q, e.q);
      end
    end
  end

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 40) begin tick(); g++; end
    chk("wait_ready_timeout", in_ready, 1);
  endtask

  task automatic wait_fd();
    int g = 0;
    while (!frame_done && g < 40) begin tick(); g++; end
    chk("wait_fd_timeout", frame_done, 1);
    tick();
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    int n;
    wait_ready();
    in_valid = 1'b1; in_data = v.w; fill_bit = v.f; rotate = v.r;
    tick();
    e.stream = v.exp_stream; e.q = v.exp_q;
    sb.push_back(e);
    in_valid = 1'b0;
    chk("load_pe", PE, 0);
    chk("load_p", P, v.w);
    chk("load_busy", busy, 1);
    chk("load_ready", in_ready, 0);
    n = 1;
    while (!frame_done && n < 20) begin
      if (v.noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 4'($urandom);
        fill_bit = ~v.f;
      end
      tick();
      n++;
      if (n == 3) begin
        chk("shift_p_hold", P, v.w);
        chk("shift_pe", PE, 1);
        if (!v.r) begin
          chk("shift_j", J, v.f);
          chk("shift_k", K, v.f);
        end
      end
    end
    in_valid = 1'b0;
    chk("fd_latency", n, L + 1);
    chk("fd_p_hold", P, v.w);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t rv[2];
    exp_t e;
    int n;
    logic seen;

    vecs[0] = '{w: 4'b1011, f: 1'b0, r: 1'b0, noise: 1'b0, exp_stream: 4'b1011, exp_q: 4'b0000};
    vecs[1] = '{w: 4'hF,    f: 1'b1, r: 1'b0, noise: 1'b0, exp_stream: 4'hF,    exp_q: 4'hF};
    vecs[2] = '{w: 4'h6,    f: 1'b1, r: 1'b0, noise: 1'b1, exp_stream: 4'h6,    exp_q: 4'hF};
    vecs[3] = '{w: 4'h0,    f: 1'b1, r: 1'b0, noise: 1'b0, exp_stream: 4'h0,    exp_q: 4'hF};
    vecs[4] = '{w: 4'h9,    f: 1'b0, r: 1'b0, noise: 1'b1, exp_stream: 4'h9,    exp_q: 4'h0};
    rv[0]   = '{w: 4'b1001, f: 1'b0, r: 1'b1, noise: 1'b0, exp_stream: 4'b1001, exp_q: 4'b1001};
    rv[1]   = '{w: 4'b0110, f: 1'b1, r: 1'b1, noise: 1'b1, exp_stream: 4'b0110, exp_q: 4'b0110};

    // Reset state, observed without any clock edge.
    #1 MR = 1'b0;
    #1;
    chk("rst_p", P, 0);
    chk("rst_pe", PE, 1);
    chk("rst_j", J, 0);
    chk("rst_k", K, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_fd", frame_done, 0);
    tick(); tick();
    MR = 1'b1;
    tick();

    // Table-driven single frames.
    for (int i = 0; i < 5; i++) send(vecs[i]);
    tick();

    // Back-to-back with in_valid held high: second load 6 cycles after the first.
    wait_ready();
    in_valid = 1'b1; in_data = 4'hA; fill_bit = 1'b0;
    tick();
    e.stream = 4'hA; e.q = 4'h0; sb.push_back(e);
    chk("b2b_pe_first", PE, 0);
    in_data = 4'h5; fill_bit = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (PE) chk("b2b_p_hold", P, 4'hA);
    end while (PE && n < 20);
    e.stream = 4'h5; e.q = 4'hF; sb.push_back(e);
    in_valid = 1'b0;
    chk("b2b_spacing", n, 6);
    chk("b2b_p_second", P, 4'h5);
    wait_fd();
    tick();

    // Reset in the middle of SHIFT: frame dropped, no frame_done.
    wait_ready();
    in_valid = 1'b1; in_data = 4'hC; fill_bit = 1'b1;
    tick();
    e.stream = 4'hC; e.q = 4'hF; sb.push_back(e);
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 MR = 1'b0;
    sb.delete();
    #1;
    chk("midrst_p", P, 0);
    chk("midrst_pe", PE, 1);
    chk("midrst_j", J, 0);
    chk("midrst_k", K, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_fd", frame_done, 0);
    seen = 1'b0;
    tick(); tick();
    MR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    chk("midrst_no_fd", seen, 0);
    send('{w: 4'h3, f: 1'b0, r: 1'b0, noise: 1'b0, exp_stream: 4'h3, exp_q: 4'h0});
    tick();

`ifdef SR195_ROTATE_EN
    for (int i = 0; i < 2; i++) send(rv[i]);
    tick();
`endif

    // GAP_CYCLES=2 instance: frame timing, gap outputs and throughput.
    g_valid = 1'b1; g_data = 4'hC; g_fill = 1'b1;
    n = 0;
    while (!g_ready && n < 40) begin tick(); n++; end
    chk("gap_ready_timeout", g_ready, 1);
    tick();
    chk("gap_load_pe", g_PE, 0);
    chk("gap_load_p", g_P, 4'hC);
    for (n = 2; n <= 9; n++) begin
      tick();
      if (n == 3) begin
        chk("gap_shift_j", g_J, 1);
        chk("gap_shift_k", g_K, 1);
      end
      if (n == 5) chk("gap_fd", g_fd, 1);
      if (n == 6 || n == 7) begin
        chk("gap_busy", g_busy, 1);
        chk("gap_ready_low", g_ready, 0);
        chk("gap_pe", g_PE, 1);
        chk("gap_j", g_J, 0);
        chk("gap_k", g_K, 1);
        chk("gap_no_fd", g_fd, 0);
      end
      if (n == 8) chk("gap_ready_back", g_ready, 1);
    end
    chk("gap_second_load", g_PE, 0);
    g_valid = 1'b0;

    tick(); tick(); tick();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
